ggt_controller: RTL and testbench
=================================

GGT_CONTROLLER -- requirements
Module: ggt_controller

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width.
REQ-002 Parameter TIMEOUT, default 64, max cycles spent in WAIT per modulo operation.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  request; sampled only in IDLE.
REQ-006 Zahl1_i  in  WIDTH  first operand, captured with start_i.
REQ-007 Zahl2_i  in  WIDTH  second operand, captured with start_i.
REQ-008 busy_o  out  1  high in every state except IDLE.
REQ-009 valid_o  out  1  one-cycle pulse, result available.
REQ-010 ergebnis_o  out  WIDTH  gcd result, held until next accepted start.
REQ-011 err_o  out  1  timeout flag, held until next accepted start.
REQ-012 schritte_o  out  8  count of completed modulo operations, held with ergebnis_o.
REQ-013 mod_start_o  out  1  start pulse to the modulo unit.
REQ-014 mod_zahl1_o, mod_zahl2_o  out  WIDTH  modulo operands (dividend, divisor).
REQ-015 mod_valid_i  in  1  modulo unit done.
REQ-016 mod_ergebnis_i  in  WIDTH  modulo remainder.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, DONE, ERROR; Euclid loop: a <= b, b <= a mod b until remainder 0.
REQ-018 IDLE, start_i=1 at edge: a<=Zahl1_i, b<=Zahl2_i, err_o<=0, schritte_o<=0; b==0 -> DONE with ergebnis_o<=a; else a==0 -> DONE with ergebnis_o<=b; else -> ISSUE.
REQ-019 ISSUE lasts exactly one cycle: mod_start_o=1, mod_zahl1_o=a, mod_zahl2_o=b; next state WAIT.
REQ-020 mod_zahl1_o/mod_zahl2_o stay stable from ISSUE through the end of WAIT.
REQ-021 WAIT, mod_valid_i=1 at edge: schritte_o increments (saturating at 255); remainder 0 -> ergebnis_o<=b, DONE; otherwise a<=b, b<=remainder, ISSUE.
REQ-022 WAIT timeout counter clears on entry to WAIT; when TIMEOUT cycles elapse without mod_valid_i -> ERROR.
REQ-023 DONE: valid_o=1 for exactly one cycle, then IDLE.
REQ-024 ERROR: ergebnis_o<=0, err_o<=1, valid_o=1 for exactly one cycle, then IDLE.
REQ-025 start_i outside IDLE is ignored; it is not queued.
REQ-026 mod_valid_i outside WAIT is ignored.
REQ-027 Latency: degenerate case (either operand 0) valid_o is high in the cycle after the sampling edge; otherwise each step costs 1 ISSUE cycle plus the modulo latency, followed by 1 DONE cycle.
REQ-028 mod_valid_i in the same cycle the timeout expires: the result wins and no error is raised.
REQ-029 valid_o and mod_start_o are decoded from the registered state; no combinational path from any input to any output.

Reset
REQ-030 rst_i low forces IDLE immediately and clears every output and internal register to 0, regardless of clk.
REQ-031 Reset mid-operation abandons the computation; a late mod_valid_i after reset release is ignored (REQ-026).

Verification
REQ-032 Bench models the modulo unit behaviourally with a 3-cycle latency and covers the scenarios below.
REQ-033 (24255, 9540) -> remainders 5175, 4365, 810, 315, 180, 135, 45, 0; ergebnis_o=45, schritte_o=8, exactly 8 mod_start_o pulses, one valid_o pulse.
REQ-034 (12, 18) -> operations 12 mod 18=12, 18 mod 12=6, 12 mod 6=0; ergebnis_o=6, schritte_o=3.
REQ-035 (100, 0) -> ergebnis_o=100 with valid_o in the cycle after start, no mod_start_o, schritte_o=0; (0, 0) -> ergebnis_o=0, valid_o, err_o=0.
REQ-036 Modulo model never answers -> TIMEOUT=64 cycles after entering WAIT: err_o=1, valid_o pulse, ergebnis_o=0; next start clears err_o.
REQ-037 rst_i low during WAIT, then released, then mod_valid_i pulsed -> all outputs 0, state IDLE, no valid_o; start_i pulsed while busy -> operands unchanged, single valid_o.

Source files
------------

// File: rtl/ggt_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : ggt_controller_if
// Description : Bundles the request/response signals of ggt_controller with
//               the handshake to its external modulo unit.
//               slave  : view taken by ggt_controller itself
//               master : view taken by the requester / modulo unit side
//               Request   : start_i, Zahl1_i, Zahl2_i
//               Response  : busy_o, valid_o, ergebnis_o, err_o, schritte_o
//               Modulo    : mod_start_o, mod_zahl1_o, mod_zahl2_o,
//                           mod_valid_i, mod_ergebnis_i
// Revision    : 1.0 - initial release
// ============================================================================
interface ggt_controller_if #(
  parameter int WIDTH = 16
);
  logic             start_i;
  logic [WIDTH-1:0] Zahl1_i;
  logic [WIDTH-1:0] Zahl2_i;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] ergebnis_o;
  logic             err_o;
  logic [7:0]       schritte_o;
  logic             mod_start_o;
  logic [WIDTH-1:0] mod_zahl1_o;
  logic [WIDTH-1:0] mod_zahl2_o;
  logic             mod_valid_i;
  logic [WIDTH-1:0] mod_ergebnis_i;

  modport slave (
    input  start_i, Zahl1_i, Zahl2_i, mod_valid_i, mod_ergebnis_i,
    output busy_o, valid_o, ergebnis_o, err_o, schritte_o,
           mod_start_o, mod_zahl1_o, mod_zahl2_o
  );

  modport master (
    output start_i, Zahl1_i, Zahl2_i, mod_valid_i, mod_ergebnis_i,
    input  busy_o, valid_o, ergebnis_o, err_o, schritte_o,
           mod_start_o, mod_zahl1_o, mod_zahl2_o
  );
endinterface
`default_nettype wire

// File: rtl/ggt_controller.sv
`default_nettype none
// ============================================================================
// Module      : ggt_controller
// Description : Euclidean GCD sequencer. Repeatedly hands (a, b) to an
//               external modulo unit and replaces (a, b) with (b, a mod b)
//               until the remainder is zero. A watchdog aborts a modulo
//               operation that does not answer within TIMEOUT cycles.
// Ports       : clk   - single clock, rising edge
//               rst_i - asynchronous active-low reset
//               bus   - ggt_controller_if.slave (request, result, modulo
//                       unit handshake)
// Revision    : 1.0 - initial release
// ============================================================================
module ggt_controller #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_i,
  ggt_controller_if.slave     bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ISSUE = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_DONE  = 3'd3;
  localparam logic [2:0] c_ERROR = 3'd4;

  localparam int              c_TMO_W    = $clog2(TIMEOUT + 1);
  // Counter value seen during the last permitted WAIT cycle.
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = (c_TMO_W)'(TIMEOUT - 1);

  logic [2:0]         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [c_TMO_W-1:0] r_tmo;
  logic [WIDTH-1:0]   r_ergebnis;
  logic               r_err;
  logic [7:0]         r_schritte;

  // All outputs come straight from registers or from a decode of r_state,
  // so no input reaches an output combinationally.
  assign bus.busy_o      = (r_state != c_IDLE);
  assign bus.valid_o     = (r_state == c_DONE) || (r_state == c_ERROR);
  assign bus.mod_start_o = (r_state == c_ISSUE);
  // a/b only change when WAIT is left, so the operands are stable from
  // ISSUE through the end of WAIT.
  assign bus.mod_zahl1_o = r_a;
  assign bus.mod_zahl2_o = r_b;
  assign bus.ergebnis_o  = r_ergebnis;
  assign bus.err_o       = r_err;
  assign bus.schritte_o  = r_schritte;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= c_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_tmo      <= '0;
      r_ergebnis <= '0;
      r_err      <= 1'b0;
      r_schritte <= 8'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start_i) begin
            r_a        <= bus.Zahl1_i;
            r_b        <= bus.Zahl2_i;
            r_err      <= 1'b0;
            r_schritte <= 8'd0;
            // gcd(x, 0) = x and gcd(0, y) = y need no modulo operation.
            if (bus.Zahl2_i == '0) begin
              r_ergebnis <= bus.Zahl1_i;
              r_state    <= c_DONE;
            end else if (bus.Zahl1_i == '0) begin
              r_ergebnis <= bus.Zahl2_i;
              r_state    <= c_DONE;
            end else begin
              r_state    <= c_ISSUE;
            end
          end
        end

        c_ISSUE: begin
          r_tmo   <= '0;
          r_state <= c_WAIT;
        end

        c_WAIT: begin
          // A response arriving in the expiry cycle takes priority.
          if (bus.mod_valid_i) begin
            if (r_schritte != 8'hFF) begin
              r_schritte <= r_schritte + 8'd1;
            end
            if (bus.mod_ergebnis_i == '0) begin
              r_ergebnis <= r_b;
              r_state    <= c_DONE;
            end else begin
              r_a     <= r_b;
              r_b     <= bus.mod_ergebnis_i;
              r_state <= c_ISSUE;
            end
          end else if (r_tmo == c_TMO_LAST) begin
            r_ergebnis <= '0;
            r_err      <= 1'b1;
            r_state    <= c_ERROR;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        c_DONE: begin
          r_state <= c_IDLE;
        end

        c_ERROR: begin
          r_state <= c_IDLE;
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ggt_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ggt_controller
// Description : Directed self-checking bench for ggt_controller with a
//               behavioural 3-cycle-latency modulo unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ggt_controller;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ggt_controller_if #(.WIDTH(16)) bus ();

  ggt_controller #(.WIDTH(16), .TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Modulo unit model plus forced-response path for directed corner cases.
  logic        mod_en;
  logic        m_valid;
  logic [15:0] m_rem;
  logic        f_valid;
  logic [15:0] f_rem;
  assign bus.mod_valid_i    = m_valid | f_valid;
  assign bus.mod_ergebnis_i = f_valid ? f_rem : m_rem;

  int          mstart_cnt;
  int          valid_cnt;
  int          stab_err;
  int          rem_n;
  int          rem_log [64];
  int          d;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [15:0] rem;

  initial begin
    m_valid = 1'b0; m_rem = '0; mstart_cnt = 0; valid_cnt = 0;
    stab_err = 0; rem_n = 0; d = 0; op1 = '0; op2 = '0; rem = '0;
  end

  always @(negedge clk) begin
    if (bus.mod_start_o) mstart_cnt++;
    if (bus.valid_o)     valid_cnt++;
    m_valid = 1'b0;
    if (!mod_en) begin
      d = 0;
    end else if (d > 0) begin
      if (bus.mod_zahl1_o !== op1 || bus.mod_zahl2_o !== op2) stab_err++;
      d--;
      if (d == 0) begin
        m_valid = 1'b1;
        m_rem   = rem;
        if (rem_n < 64) rem_log[rem_n] = int'(rem);
        rem_n++;
      end
    end
    if (mod_en && bus.mod_start_o) begin
      op1 = bus.mod_zahl1_o;
      op2 = bus.mod_zahl2_o;
      rem = (op2 != 0) ? op1 % op2 : 16'd0;
      d   = 3;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presents operands for one edge; returns at the negedge of the first
  // cycle after the sampling edge.
  task automatic do_start(input logic [15:0] z1, input logic [15:0] z2);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.Zahl1_i = z1;
    bus.Zahl2_i = z2;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // n = index of the cycle (after the sampling edge) in which valid_o is seen.
  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.valid_o && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int ms0;
  int vc0;
  int rn0;
  int exp_rem [8];

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; mod_en = 1'b1; f_valid = 1'b0; f_rem = '0;
    bus.start_i = 1'b0; bus.Zahl1_i = '0; bus.Zahl2_i = '0;
    exp_rem = '{5175, 4365, 810, 315, 180, 135, 45, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy_o, 0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_erg", bus.ergebnis_o, 0);
    check("rst_err", bus.err_o, 0);
    check("rst_schritte", bus.schritte_o, 0);
    check("rst_mstart", bus.mod_start_o, 0);
    check("rst_mz1", bus.mod_zahl1_o, 0);
    check("rst_mz2", bus.mod_zahl2_o, 0);
    rst_n = 1'b1;

    // gcd(24255, 9540) = 45 over eight modulo steps
    ms0 = mstart_cnt; vc0 = valid_cnt; rn0 = rem_n;
    do_start(16'd24255, 16'd9540);
    wait_valid(n);
    check("big_latency", n, 33);
    check("big_erg", bus.ergebnis_o, 45);
    check("big_schritte", bus.schritte_o, 8);
    check("big_err", bus.err_o, 0);
    check("big_mstarts", mstart_cnt - ms0, 8);
    check("big_nrem", rem_n - rn0, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("big_rem%0d", i), rem_log[(rn0 + i) % 64], exp_rem[i]);
    end
    @(negedge clk);
    check("big_valid_1cyc", bus.valid_o, 0);
    check("big_idle", bus.busy_o, 0);
    check("big_vpulses", valid_cnt - vc0, 1);
    check("big_stable", stab_err, 0);

    // gcd(12, 18) = 6, three steps
    do_start(16'd12, 16'd18);
    wait_valid(n);
    check("s_latency", n, 13);
    check("s_erg", bus.ergebnis_o, 6);
    check("s_schritte", bus.schritte_o, 3);

    // Degenerate operands
    ms0 = mstart_cnt;
    do_start(16'd100, 16'd0);
    check("d100_valid", bus.valid_o, 1);
    check("d100_erg", bus.ergebnis_o, 100);
    check("d100_schritte", bus.schritte_o, 0);
    @(negedge clk);
    check("d100_mstarts", mstart_cnt - ms0, 0);
    do_start(16'd0, 16'd0);
    check("d00_valid", bus.valid_o, 1);
    check("d00_erg", bus.ergebnis_o, 0);
    check("d00_err", bus.err_o, 0);
    do_start(16'd0, 16'd7);
    check("d07_valid", bus.valid_o, 1);
    check("d07_erg", bus.ergebnis_o, 7);

    // Modulo unit never answers: timeout
    @(negedge clk);
    mod_en = 1'b0;
    do_start(16'd40, 16'd15);
    wait_valid(n);
    check("to_latency", n, 66);
    check("to_err", bus.err_o, 1);
    check("to_erg", bus.ergebnis_o, 0);
    check("to_schritte", bus.schritte_o, 0);
    @(negedge clk);
    check("to_valid_1cyc", bus.valid_o, 0);
    mod_en = 1'b1;
    do_start(16'd9, 16'd6);
    check("to_err_cleared", bus.err_o, 0);
    check("to_busy_next", bus.busy_o, 1);
    wait_valid(n);
    check("after_to_latency", n, 9);
    check("after_to_erg", bus.ergebnis_o, 3);
    check("after_to_schritte", bus.schritte_o, 2);

    // Response in the very cycle the timeout expires: result wins
    @(negedge clk);
    mod_en = 1'b0;
    do_start(16'd7, 16'd5);
    repeat (64) @(negedge clk);
    check("race_not_expired", bus.valid_o, 0);
    check("race_busy", bus.busy_o, 1);
    f_valid = 1'b1;
    f_rem   = 16'd0;
    @(negedge clk);
    f_valid = 1'b0;
    check("race_valid", bus.valid_o, 1);
    check("race_err", bus.err_o, 0);
    check("race_erg", bus.ergebnis_o, 5);
    check("race_schritte", bus.schritte_o, 1);

    // start_i while busy is ignored and not queued
    @(negedge clk);
    mod_en = 1'b1;
    vc0 = valid_cnt;
    do_start(16'd12, 16'd18);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.Zahl1_i = 16'd99;
    bus.Zahl2_i = 16'd33;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("busy_mz1", bus.mod_zahl1_o, 12);
    check("busy_mz2", bus.mod_zahl2_o, 18);
    wait_valid(n);
    check("busy_erg", bus.ergebnis_o, 6);
    check("busy_schritte", bus.schritte_o, 3);
    repeat (5) @(negedge clk);
    check("busy_vpulses", valid_cnt - vc0, 1);
    check("busy_no_queue", bus.busy_o, 0);

    // Asynchronous reset during WAIT, then a late response
    mod_en = 1'b0;
    do_start(16'd12, 16'd18);
    @(negedge clk);
    check("pre_rst_busy", bus.busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy_o, 0);
    check("arst_erg", bus.ergebnis_o, 0);
    check("arst_schritte", bus.schritte_o, 0);
    check("arst_mz1", bus.mod_zahl1_o, 0);
    check("arst_mz2", bus.mod_zahl2_o, 0);
    check("arst_valid", bus.valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vc0 = valid_cnt;
    @(negedge clk);
    f_valid = 1'b1;
    f_rem   = 16'd3;
    @(negedge clk);
    f_valid = 1'b0;
    @(negedge clk);
    check("late_busy", bus.busy_o, 0);
    check("late_erg", bus.ergebnis_o, 0);
    check("late_schritte", bus.schritte_o, 0);
    check("late_err", bus.err_o, 0);
    check("late_mz1", bus.mod_zahl1_o, 0);
    check("late_vpulses", valid_cnt - vc0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
